// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter
//   Two-port (CPU, video) arbiter in front of a RAM BRAM and a VRAM BRAM that
//   share one address/write-data bus. Offers strictly alternate between the
//   ports. A port may strobe a request only in the cycle after it saw its
//   ready offer. One transaction is in flight at a time.
//
//   Timeline of a read, counted from the strobe cycle S:
//     S+0        ACCEPT  request latched
//     S+1        ISSUE   memory enable pulse
//     S+2..S+L+1 WAIT    BRAM pipeline
//                        (rdata is sampled on the last WAIT edge)
//     S+L+2      RESP    rsp_valid pulse
//
// Ports
//   clk_in, rst_in           clock, asynchronous active-high reset
//   ad_in                    VRAM back-buffer bank select (latched on accept)
//   cpu_* / vid_*            requester ports:
//                            valid/we/type/addr/data in;
//                            ready, rsp_valid, rsp_data out
//   mem_addr_out             RAM: addr[11:0]
//                            VRAM: {3'b0, bank, addr[7:0]}
//   mem_we_out, mem_wdata_out, ram_en_out, vram_en_out
//                            one-cycle issue pulse, 0 otherwise
//   ram_rdata_in, vram_rdata_in
//                            BRAM read data, RD_LATENCY cycles after issue
//   proto_err_out            sticky: a strobe arrived outside its accept slot
//   busy_out                 high in every state except OFFER

module chip8_mem_arbiter #(
  parameter int RD_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ad_in,

  input  logic        cpu_valid_in,
  input  logic        cpu_we_in,
  input  logic        cpu_type_in,
  input  logic [15:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  output logic        cpu_ready_out,
  output logic        cpu_rsp_valid_out,
  output logic [7:0]  cpu_rsp_data_out,

  input  logic        vid_valid_in,
  input  logic        vid_we_in,
  input  logic        vid_type_in,
  input  logic [15:0] vid_addr_in,
  input  logic [7:0]  vid_data_in,
  output logic        vid_ready_out,
  output logic        vid_rsp_valid_out,
  output logic [7:0]  vid_rsp_data_out,

  output logic [11:0] mem_addr_out,
  output logic        mem_we_out,
  output logic [7:0]  mem_wdata_out,
  output logic        ram_en_out,
  output logic        vram_en_out,
  input  logic [7:0]  ram_rdata_in,
  input  logic [7:0]  vram_rdata_in,

  output logic        proto_err_out,
  output logic        busy_out
);

  typedef enum logic [2:0] {
    S_OFFER,
    S_ACCEPT,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [2:0] WAIT_LOAD = 3'(RD_LATENCY - 1);

  state_t      state;
  logic        ptr;
  logic        l_port;
  logic        l_we;
  logic        l_type;
  logic [11:0] l_addr;
  logic [7:0]  l_data;
  logic [2:0]  wait_cnt;
  logic [7:0]  cpu_rsp_data_q;
  logic [7:0]  vid_rsp_data_q;
  logic        proto_err_q;

  // Request fields of the port currently holding the offer.
  logic        sel_valid;
  logic        sel_we;
  logic        sel_type;
  logic [15:0] sel_addr;
  logic [7:0]  sel_data;
  logic        bad_strobe;

  always_comb begin
    sel_valid = ptr ? vid_valid_in : cpu_valid_in;
    sel_we    = ptr ? vid_we_in    : cpu_we_in;
    sel_type  = ptr ? vid_type_in  : cpu_type_in;
    sel_addr  = ptr ? vid_addr_in  : cpu_addr_in;
    sel_data  = ptr ? vid_data_in  : cpu_data_in;
  end

  // A strobe is legal only in ACCEPT for the port that was just offered.
  always_comb begin
    bad_strobe = 1'b0;
    if (cpu_valid_in && !(state == S_ACCEPT && !ptr)) bad_strobe = 1'b1;
    if (vid_valid_in && !(state == S_ACCEPT &&  ptr)) bad_strobe = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= S_OFFER;
      ptr            <= 1'b0;
      l_port         <= 1'b0;
      l_we           <= 1'b0;
      l_type         <= 1'b0;
      l_addr         <= '0;
      l_data         <= '0;
      wait_cnt       <= '0;
      cpu_rsp_data_q <= '0;
      vid_rsp_data_q <= '0;
      proto_err_q    <= 1'b0;
    end else begin
      if (bad_strobe) proto_err_q <= 1'b1;

      case (state)
        S_OFFER: state <= S_ACCEPT;

        S_ACCEPT: begin
          if (sel_valid) begin
            l_port <= ptr;
            l_we   <= sel_we;
            l_type <= sel_type;
            l_data <= sel_data;
            // Address is truncated and the VRAM bank frozen here, so later
            // ad_in changes cannot leak into this transaction.
            l_addr <= sel_type ? {3'b000, ad_in, sel_addr[7:0]}
                               : sel_addr[11:0];
            state  <= S_ISSUE;
          end else begin
            ptr   <= ~ptr;
            state <= S_OFFER;
          end
        end

        S_ISSUE: begin
          if (l_we) begin
            ptr   <= ~ptr;
            state <= S_OFFER;
          end else begin
            wait_cnt <= WAIT_LOAD;
            state    <= S_WAIT;
          end
        end

        // RD_LATENCY-1 counted cycles, then one more in which the BRAM output
        // is valid and gets captured into the requester's data register.
        S_WAIT: begin
          if (wait_cnt == 3'd0) begin
            if (l_port) vid_rsp_data_q <= l_type ? vram_rdata_in : ram_rdata_in;
            else        cpu_rsp_data_q <= l_type ? vram_rdata_in : ram_rdata_in;
            state <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end

        S_RESP: begin
          ptr   <= ~ptr;
          state <= S_OFFER;
        end

        default: state <= S_OFFER;
      endcase
    end
  end

  logic offer;
  logic issue;

  // Reset forces OFFER with ptr=0, so the offer is masked by rst_in to keep
  // every output low while reset is held.
  assign offer = (state == S_OFFER) && !rst_in;
  assign issue = (state == S_ISSUE);

  assign cpu_ready_out     = offer && !ptr;
  assign vid_ready_out     = offer &&  ptr;
  assign cpu_rsp_valid_out = (state == S_RESP) && !l_port;
  assign vid_rsp_valid_out = (state == S_RESP) &&  l_port;
  assign cpu_rsp_data_out  = cpu_rsp_data_q;
  assign vid_rsp_data_out  = vid_rsp_data_q;

  assign mem_addr_out  = issue ? l_addr : 12'h000;
  assign mem_we_out    = issue && l_we;
  assign mem_wdata_out = issue ? l_data : 8'h00;
  assign ram_en_out    = issue && !l_type;
  assign vram_en_out   = issue &&  l_type;

  assign proto_err_out = proto_err_q;
  assign busy_out      = (state != S_OFFER);

endmodule
